// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Writes the selected result straight to the register file write port.
module div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [4:0]            rd_in,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  wr_en,
  output logic [4:0]            wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [W-1:0]  MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          rsel_q, rsel_d;
  logic [4:0]    rd_q, rd_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W:0]    rem_q, rem_d;
  logic [W-1:0]  dsr_q, dsr_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic          wen_q, wen_d;
  logic [4:0]    waddr_q, waddr_d;
  logic [W-1:0]  wdata_q, wdata_d;

  logic          a_neg, b_neg;
  logic [W-1:0]  a_abs, b_abs;
  logic [W:0]    rem_sh, diff;
  logic [W-1:0]  q_fix, r_fix;

  assign a_neg  = ~op[0] & dividend[W-1];
  assign b_neg  = ~op[0] & divisor[W-1];
  assign a_abs  = a_neg ? -dividend : dividend;
  assign b_abs  = b_neg ? -divisor : divisor;
  assign rem_sh = {rem_q[W-1:0], quo_q[W-1]};
  assign diff   = rem_sh - {1'b0, dsr_q};
  assign q_fix  = qneg_q ? -quo_q : quo_q;
  assign r_fix  = rneg_q ? -rem_q[W-1:0] : rem_q[W-1:0];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rsel_d  = rsel_q;
    rd_d    = rd_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          count_d = '0;
          rsel_d  = op[1];
          rd_d    = rd_in;
          quo_d   = a_abs;
          rem_d   = '0;
          dsr_d   = b_abs;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          // Special cases skip the iterations by presetting the count.
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = {1'b0, dividend};
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            count_d = LAST;
          end else if (!op[0] && dividend == MIN && divisor == '1) begin
            quo_d   = MIN;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            count_d = LAST;
          end
        end
      end
      CALC: begin
        if (count_q == LAST) begin
          state_d = DONE;
          wen_d   = (rd_q != 5'd0);
          waddr_d = rd_q;
          wdata_d = rsel_q ? r_fix : q_fix;
        end else begin
          count_d = count_q + 1'b1;
          if (diff[W]) begin
            rem_d = rem_sh;
            quo_d = {quo_q[W-2:0], 1'b0};
          end else begin
            rem_d = diff;
            quo_d = {quo_q[W-2:0], 1'b1};
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      rsel_q  <= 1'b0;
      rd_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rsel_q  <= rsel_d;
      rd_q    <= rd_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign wr_en   = wen_q;
  assign wr_addr = waddr_q;
  assign wr_data = wdata_q;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed RV32M cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_div_unit;
  localparam int W = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = '0;
  logic [4:0]    rd_in = '0;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          busy;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [W-1:0]  wr_data;

  div_unit #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(rst), .start(start), .op(op), .rd_in(rd_in),
    .dividend(dividend), .divisor(divisor), .busy(busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   nwr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] o,
      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (!o[0]) begin
      if (a == MIN && b == 32'hFFFF_FFFF) begin
        q = MIN;
        r = 0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return o[1] ? r : q;
  endfunction

  function automatic bit is_special(input logic [1:0] o,
      input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!o[0] && a == MIN && b == 32'hFFFF_FFFF);
  endfunction

  // Monitor: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        nwr++;
        if (sb.size() == 0) begin
          chk("spurious_wr_en", {31'd0, wr_en}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_addr"}, {27'd0, wr_addr}, {27'd0, e.rd});
          chk({e.name, "_data"}, wr_data, e.data);
          chk({e.name, "_latency"}, cyc, e.due);
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        chk({sb[0].name, "_missing_wr"}, {31'd0, wr_en}, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic issue(input string name, input logic [1:0] o,
      input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   guard = 0;
    while (busy && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (busy) chk({name, "_idle_timeout"}, {31'd0, busy}, 32'd0);
    start = 1'b1;
    op = o;
    rd_in = rd;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    rd_in = 5'($urandom);
    if (rd != 0) begin
      e.rd = rd;
      e.data = ref_model(o, a, b);
      e.due = cyc + (is_special(o, a, b) ? 1 : 33);
      e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic busy_len(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy || sb.size() > 0) && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    int n;
    int w0;
    logic [1:0]  o;
    logic [31:0] a, b;

    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_wr_en", {31'd0, wr_en}, 0);
    chk("rst_wr_addr", {27'd0, wr_addr}, 0);
    chk("rst_wr_data", wr_data, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue("divu_100_7", 2'b01, 5'd5, 100, 7);
    busy_len(n);
    chk("divu_busy_len", n, 34);
    issue("remu_100_7", 2'b11, 5'd6, 100, 7);
    issue("div_m7_2", 2'b00, 5'd1, -7, 2);
    issue("rem_m7_2", 2'b10, 5'd2, -7, 2);
    issue("div_7_m2", 2'b00, 5'd3, 7, -2);
    issue("rem_7_m2", 2'b10, 5'd4, 7, -2);
    issue("divu_5_0", 2'b01, 5'd7, 5, 0);
    busy_len(n);
    chk("special_busy_len", n, 2);
    issue("remu_5_0", 2'b11, 5'd8, 5, 0);
    issue("div_m5_0", 2'b00, 5'd9, -5, 0);
    issue("rem_m5_0", 2'b10, 5'd10, -5, 0);
    issue("div_ovf", 2'b00, 5'd11, MIN, 32'hFFFF_FFFF);
    issue("rem_ovf", 2'b10, 5'd12, MIN, 32'hFFFF_FFFF);
    issue("divu_ovf_ops", 2'b01, 5'd13, MIN, 32'hFFFF_FFFF);
    wait_idle();

    w0 = nwr;
    issue("busy_ignore", 2'b01, 5'd14, 100, 7);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    op = 2'b01;
    rd_in = 5'd20;
    dividend = 50;
    divisor = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    start = 1'b1;
    rd_in = 5'd21;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    chk("busy_ignore_writes", nwr - w0, 1);

    w0 = nwr;
    issue("rd0", 2'b00, 5'd0, 1000, 3);
    busy_len(n);
    chk("rd0_busy_len", n, 34);
    chk("rd0_no_write", nwr - w0, 0);

    issue("abort", 2'b01, 5'd15, 12345, 7);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_wr_en", {31'd0, wr_en}, 0);
    sb.delete();
    w0 = nwr;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_write", nwr - w0, 0);
    issue("divu_9_3", 2'b01, 5'd16, 9, 3);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = 32'hFFFF_FFFF;
        2: a = MIN;
        3: b = $urandom_range(1, 300);
        default: ;
      endcase
      issue($sformatf("rand%0d", i), o, 5'($urandom_range(1, 31)), a, b);
    end
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
